// File: rtl/scen_cmd_responder.sv
// scen_cmd_responder: register-array command responder with fixed-latency, in-order, credit-flow-controlled responses.
// Optional statistics ports are enabled by defining SCEN_RSP_STATS_EN.
module scen_cmd_responder #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int DEPTH     = 16,
  parameter int LATENCY   = 3,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [ID_W-1:0]   cmd_id,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
`ifdef SCEN_RSP_STATS_EN
  ,
  output logic [15:0]       stat_cmds,
  output logic [15:0]       stat_errs,
  output logic [15:0]       stat_stall
`endif
);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   id;
  } rsp_t;
  logic [DATA_W-1:0] mem_q [DEPTH];
  rsp_t              pipe_q [LATENCY];
  logic [LATENCY-1:0] pv_q;
  rsp_t              fifo_q [RSP_DEPTH];
  logic [AW:0]       wp_q, rp_q, credit_q, credit_d;
  logic              cmd_ready_q, acc, pop, push, err, empty, full, in_range;
  logic [IW-1:0]     idx;
  rsp_t              new_rsp, head;
  always_comb begin
    idx      = cmd_addr[IW-1:0];
    in_range = {1'b0, cmd_addr} < (ADDR_W+1)'(DEPTH);
    err      = (cmd_op == 2'b11) || !in_range;
    new_rsp  = '{err: err, rdata: (!err && cmd_op == 2'b10) ? mem_q[idx] : '0, id: cmd_id};
    acc      = cmd_valid & cmd_ready_q;
    push     = pv_q[LATENCY-1];
    empty    = wp_q == rp_q;
    full     = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
    pop      = !empty & rsp_ready;
    head     = fifo_q[rp_q[AW-1:0]];
    credit_d = credit_q + (AW+1)'(acc) - (AW+1)'(pop);
  end
  always_comb begin
    cmd_ready = cmd_ready_q;
    rsp_valid = !empty;
    rsp_id    = head.id;
    rsp_rdata = head.rdata;
    rsp_err   = head.err;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (acc && !err && cmd_op == 2'b01) begin
      mem_q[idx] <= cmd_wdata;
    end
  end
  // Each accepted command travels LATENCY stages before landing in the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        pv_q[i]   <= pv_q[i-1];
        pipe_q[i] <= pipe_q[i-1];
      end
      pv_q[0]   <= acc;
      pipe_q[0] <= new_rsp;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) fifo_q[wp_q[AW-1:0]] <= pipe_q[LATENCY-1];
      wp_q <= wp_q + (AW+1)'(push);
      rp_q <= rp_q + (AW+1)'(pop);
    end
  end
  // Credits cover both pipeline and FIFO occupancy, so a push can never find the FIFO full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q    <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      cmd_ready_q <= credit_d < (AW+1)'(RSP_DEPTH);
    end
  end
`ifdef SCEN_RSP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cmds  <= '0;
      stat_errs  <= '0;
      stat_stall <= '0;
    end else begin
      if (acc && !(&stat_cmds)) stat_cmds <= stat_cmds + 16'd1;
      if (acc && err && !(&stat_errs)) stat_errs <= stat_errs + 16'd1;
      if (cmd_valid && !cmd_ready_q && !(&stat_stall)) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif
`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> !full);
`endif
endmodule

// File: tb/tb_scen_cmd_responder.sv
// tb_scen_cmd_responder: randomized and directed stimulus with a queue scoreboard and register-array model.
module tb_scen_cmd_responder;
  localparam int ADDR_W = 8, DATA_W = 32, ID_W = 4, DEPTH = 16, LATENCY = 3, RSP_DEPTH = 4;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, rsp_err;
  logic [1:0] cmd_op = 0;
  logic [ADDR_W-1:0] cmd_addr = 0;
  logic [DATA_W-1:0] cmd_wdata = 0, rsp_rdata;
  logic [ID_W-1:0] cmd_id = 0, rsp_id;
`ifdef SCEN_RSP_STATS_EN
  logic [15:0] stat_cmds, stat_errs, stat_stall;
`endif
  scen_cmd_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH),
                       .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_id(cmd_id), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef SCEN_RSP_STATS_EN
    , .stat_cmds(stat_cmds), .stat_errs(stat_errs), .stat_stall(stat_stall)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] rdata;
    logic              err;
    int                acc_cyc;
  } exp_t;
  exp_t sb[$];
  logic [DATA_W-1:0] model [DEPTH];
  int checks = 0, fails = 0, cyc = 0, acc_cnt = 0, pop_cnt = 0, st_cmds = 0, st_errs = 0, st_stall = 0;
  bit after_rst = 0, prev_rv = 0, stop = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) cyc++;
  // Monitor/scoreboard: all handshake decisions are taken at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_id, rsp_rdata}, 64'd0);
      sb.delete();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      after_rst = 1;
      prev_rv = 0;
      st_cmds = 0; st_errs = 0; st_stall = 0;
    end else begin
      chk("cmd_ready", cmd_ready, after_rst ? 1'b0 : (sb.size() < RSP_DEPTH));
      after_rst = 0;
      if (rsp_valid) begin
        if (sb.size() == 0) chk("unexpected_rsp", rsp_valid, 1'b0);
        else begin
          chk("rsp_fields", {rsp_id, rsp_err, rsp_rdata}, {sb[0].id, sb[0].err, sb[0].rdata});
          if (!prev_rv) chk("rsp_latency", cyc - sb[0].acc_cyc, LATENCY);
          if (rsp_ready) begin
            void'(sb.pop_front());
            pop_cnt++;
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_t e;
        e.err = cmd_op == 2'b11 || cmd_addr >= DEPTH;
        e.rdata = (!e.err && cmd_op == 2'b10) ? model[cmd_addr[3:0]] : '0;
        e.id = cmd_id;
        e.acc_cyc = cyc + 1;
        if (!e.err && cmd_op == 2'b01) model[cmd_addr[3:0]] = cmd_wdata;
        sb.push_back(e);
        acc_cnt++;
        st_cmds++;
        if (e.err) st_errs++;
      end
      if (cmd_valid && !cmd_ready) st_stall++;
      prev_rv = rsp_valid;
    end
  end
  task automatic send(input logic [1:0] op, input int addr, input logic [31:0] data, input int id);
    bit got = 0;
    cmd_valid = 1; cmd_op = op; cmd_addr = ADDR_W'(addr); cmd_wdata = data; cmd_id = ID_W'(id);
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk) got = cmd_ready;
      @(posedge clk);
      #1;
    end
    if (!got) chk("send_timeout", got, 1'b1);
    cmd_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask
  initial begin
    int mark, pmark;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    rsp_ready = 1;
    // Write then read back.
    send(2'b01, 3, 32'hDEADBEEF, 1);
    send(2'b10, 3, 0, 2);
    drain();
    // Error responses leave the array untouched.
    send(2'b10, 16, 0, 7);
    send(2'b11, 0, 32'h55, 8);
    send(2'b10, 0, 0, 9);
    drain();
    // Reset with two responses in flight.
    send(2'b01, 5, 32'h1234, 3);
    drain();
    send(2'b10, 5, 0, 4);
    send(2'b00, 0, 0, 5);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (8) @(posedge clk);
    #1;
    send(2'b10, 5, 0, 6);
    drain();
    // Back-pressure.
    rsp_ready = 0;
    mark = acc_cnt;
    fork
      for (int i = 0; i < 6; i++) send(2'b01, i, $urandom, 10 + i);
    join_none
    repeat (15) @(posedge clk);
    #1;
    chk("bp_accepted", acc_cnt - mark, 4);
    chk("bp_ready_low", cmd_ready, 1'b0);
    rsp_ready = 1;
    wait fork;
    drain();
    chk("bp_total", acc_cnt - mark, 6);
    // Streaming reads.
    pmark = pop_cnt;
    for (int i = 0; i < 20; i++) send(2'b10, i % DEPTH, 0, i);
    drain();
    chk("stream_pops", pop_cnt - pmark, 20);
    // Random traffic with random consumer stalls.
    fork
      while (!stop) begin
        @(posedge clk);
        #1 rsp_ready = $urandom_range(0, 3) != 0;
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      send(2'($urandom_range(0, 3)), $urandom_range(0, 19), $urandom, $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    stop = 1;
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1;
    drain();
`ifdef SCEN_RSP_STATS_EN
    chk("stat_cmds", stat_cmds, 16'(st_cmds));
    chk("stat_errs", stat_errs, 16'(st_errs));
    chk("stat_stall", stat_stall, 16'(st_stall));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
